// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with iterative MULT (and DIV when ALU_DIV_EN is defined)
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SUB  = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_OR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_NOR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_XOR  = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_SLL  = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_SRL  = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_SRA  = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_MULT = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_MFHI = CMD_W'(10);
    localparam logic [CMD_W-1:0] CMD_MFLO = CMD_W'(11);
`ifdef ALU_DIV_EN
    localparam logic [CMD_W-1:0] CMD_DIV  = CMD_W'(12);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL
`ifdef ALU_DIV_EN
        ,
        S_DIV
`endif
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] p_hi, p_lo, opb;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_ovf;
    logic [SHW-1:0]   shamt;
    logic             accept, is_mult, is_div, last;

    assign sum     = val1 + val2;
    assign diff    = val1 - val2;
    assign shamt   = val2[SHW-1:0];
    assign accept  = in_valid & in_ready;
    assign is_mult = (exe_cmd == CMD_MULT);
`ifdef ALU_DIV_EN
    assign is_div  = (exe_cmd == CMD_DIV);
`else
    assign is_div  = 1'b0;
`endif
    assign last     = (cnt == SHW'(WIDTH - 1));
    assign in_ready = (state_q == S_IDLE) & (~out_valid | out_ready);
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (exe_cmd)
            CMD_ADD: begin
                sc_res = sum;
                sc_ovf = (val1[WIDTH-1] == val2[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB: begin
                sc_res = diff;
                sc_ovf = (val1[WIDTH-1] != val2[WIDTH-1]) && (diff[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_AND:  sc_res = val1 & val2;
            CMD_OR:   sc_res = val1 | val2;
            CMD_NOR:  sc_res = ~(val1 | val2);
            CMD_XOR:  sc_res = val1 ^ val2;
            CMD_SLL:  sc_res = val1 << shamt;
            CMD_SRL:  sc_res = val1 >> shamt;
            CMD_SRA:  sc_res = $signed(val1) >>> shamt;
            CMD_MFHI: sc_res = hi;
            CMD_MFLO: sc_res = lo;
            default:  sc_res = '0;
        endcase
    end

    // Shift-add step: p_hi accumulates the partial product, p_lo holds the unconsumed multiplier bits.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_next_hi, mul_next_lo;
    assign mul_sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next_hi = mul_sum[WIDTH:1];
    assign mul_next_lo = {mul_sum[0], p_lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // Restoring step: p_hi is the running remainder, p_lo shifts dividend out and quotient in.
    // A zero divisor always subtracts, yielding an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_next_hi, div_next_lo;
    assign div_shift   = {p_hi, p_lo[WIDTH-1]};
    assign div_ge      = (div_shift >= {1'b0, opb});
    assign div_next_hi = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];
    assign div_next_lo = {p_lo[WIDTH-2:0], div_ge};
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mult) state_d = S_MUL;
`ifdef ALU_DIV_EN
                if (accept && is_div)  state_d = S_DIV;
`endif
            end
            S_MUL: if (last) state_d = S_IDLE;
`ifdef ALU_DIV_EN
            S_DIV: if (last) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            opb       <= '0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mult || is_div) begin
                            p_hi <= '0;
                            p_lo <= val1;
                            opb  <= val2;
                            cnt  <= '0;
                        end else begin
                            alu_out   <= sc_res;
                            zero      <= (sc_res == '0);
                            ovf       <= sc_ovf;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    p_hi <= mul_next_hi;
                    p_lo <= mul_next_lo;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        hi        <= mul_next_hi;
                        lo        <= mul_next_lo;
                        alu_out   <= mul_next_lo;
                        zero      <= (mul_next_lo == '0);
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    p_hi <= div_next_hi;
                    p_lo <= div_next_lo;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        hi        <= div_next_hi;
                        lo        <= div_next_lo;
                        alu_out   <= div_next_lo;
                        zero      <= (div_next_lo == '0);
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle against an arithmetic model
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   exe_cmd;
    logic [W-1:0] val1, val2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero, ovf, busy;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_hi, m_lo;
    logic [W-1:0] last_res;

    alu_multicycle #(.WIDTH(W), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .zero(zero), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic ov, output int lat);
        longint      s;
        logic [63:0] p;
        int          sh;
        sh  = int'(b % 32);
        res = '0;
        ov  = 1'b0;
        lat = 1;
        case (cmd)
            0, 1: begin
                if (cmd == 0) s = longint'($signed(a)) + longint'($signed(b));
                else          s = longint'($signed(a)) - longint'($signed(b));
                res = s[W-1:0];
                ov  = (s > longint'(32'h7fffffff)) || (s < -longint'(32'h80000000));
            end
            2:  res = a & b;
            3:  res = a | b;
            4:  res = ~(a | b);
            5:  res = a ^ b;
            6:  res = a << sh;
            7:  res = a >> sh;
            8:  res = $signed(a) >>> sh;
            9: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
                res = m_lo;
                lat = W + 1;
            end
            10: res = m_hi;
            11: res = m_lo;
`ifdef ALU_DIV_EN
            12: begin
                if (b == 0) begin
                    m_lo = '1;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                res = m_lo;
                lat = W + 1;
            end
`endif
            default: res = '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h80000000 - 32'($urandom_range(0, 1));
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input int cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_res;
        logic         exp_ov;
        int           exp_lat, n, lat, stall;
        model(cmd, a, b, exp_res, exp_ov, exp_lat);
        @(negedge clk);
        in_valid  = 1'b1;
        exe_cmd   = 4'(cmd);
        val1      = a;
        val2      = b;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_bound", 64'(n < 200), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        val1     = $urandom;
        val2     = $urandom;
        lat   = 1;
        stall = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) stall++;
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("lat_c%0d", cmd), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("stall_c%0d", cmd), 64'(stall), 64'(exp_lat - 1));
        check_eq($sformatf("res_c%0d_%h_%h", cmd, a, b), 64'(alu_out), 64'(exp_res));
        check_eq($sformatf("ovf_c%0d", cmd), 64'(ovf), 64'(exp_ov));
        check_eq($sformatf("zero_c%0d", cmd), 64'(zero), 64'(exp_res == 0));
        last_res = alu_out;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, exp_q[$];
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        exe_cmd = '0; val1 = '0; val2 = '0;
        m_hi = '0; m_lo = '0; last_res = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_alu_out", 64'(alu_out), 64'd0);
        check_eq("rst_zero", 64'(zero), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(0, 32'h7fffffff, 32'h1);
        check_eq("add_ovf_dir", 64'(last_res), 64'h80000000);
        do_op(8, 32'h80000000, 32'd36);
        check_eq("sra_dir", 64'(last_res), 64'hF8000000);
        do_op(7, 32'h80000000, 32'd36);
        check_eq("srl_dir", 64'(last_res), 64'h08000000);
        do_op(6, 32'h1, 32'd31);
        check_eq("sll_dir", 64'(last_res), 64'h80000000);
        do_op(9, 32'hffffffff, 32'hffffffff);
        check_eq("mult_dir", 64'(last_res), 64'h1);
        do_op(10, $urandom, $urandom);
        check_eq("mfhi_dir", 64'(last_res), 64'hFFFFFFFE);

        // Downstream stall: SUB result must hold while a second command waits.
        @(negedge clk);
        check_eq("stall_pre_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; exe_cmd = 4'd1; val1 = 32'd5; val2 = 32'd5; out_ready = 1'b0;
        @(negedge clk);
        exe_cmd = 4'd0; val1 = 32'd3; val2 = 32'd4;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_alu_out", 64'(alu_out), 64'd0);
            check_eq("hold_zero", 64'(zero), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("release_valid", 64'(out_valid), 64'd1);
        check_eq("release_alu_out", 64'(alu_out), 64'd7);
        check_eq("release_zero", 64'(zero), 64'd0);

        // Back-to-back throughput: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom;
            exp_q.push_back(ra ^ rb);
            if (i == 0) @(negedge clk);
            in_valid = 1'b1; exe_cmd = 4'd5; val1 = ra; val2 = rb;
            check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            check_eq("b2b_valid", 64'(out_valid), 64'd1);
            check_eq("b2b_res", 64'(alu_out), 64'(exp_q.pop_front()));
        end
        in_valid = 1'b0;

        // Reset during MULT aborts it and clears HI/LO.
        @(negedge clk);
        in_valid = 1'b1; exe_cmd = 4'd9; val1 = 32'h1234567; val2 = 32'h89abcde;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("mid_mult_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        do_op(11, $urandom, $urandom);
        check_eq("abort_mflo", 64'(last_res), 64'd0);

`ifdef ALU_DIV_EN
        do_op(12, 32'd100, 32'd7);
        check_eq("div_lo", 64'(last_res), 64'd14);
        do_op(10, 0, 0);
        check_eq("div_hi", 64'(last_res), 64'd2);
        do_op(12, 32'd5, 32'd0);
        check_eq("div0_lo", 64'(last_res), 64'hFFFFFFFF);
        do_op(10, 0, 0);
        check_eq("div0_hi", 64'(last_res), 64'd5);
`endif

        for (int i = 0; i < 80; i++) begin
            do_op($urandom_range(0, 15), rnd_val(), rnd_val());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
